commit_controller: RTL

COMMIT_CONTROLLER -- requirements
Module: commit_controller

---
 rtl/commit_controller_pkg.sv | 27 ++
 rtl/commit_controller.sv | 126 ++++++++++++
 2 files changed

// File: rtl/commit_controller_pkg.sv
// Shared constants for the commit controller: default widths, reserved ids,
// head_type encodings and FSM state encodings.
package commit_controller_pkg;

  // Default ROB id width; id 0 is reserved to mean "no producer".
  localparam int unsigned DEF_ROB_ID_W = 4;
  localparam int unsigned ZERO_ROB     = 0;

  // Architectural register index width; x0 is never written.
  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // ROB head entry kinds. HT_RSVD is committed exactly like HT_REG.
  typedef enum logic [1:0] {
    HT_REG    = 2'b00,
    HT_BRANCH = 2'b01,
    HT_STORE  = 2'b10,
    HT_RSVD   = 2'b11
  } head_type_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_STORE_WAIT = 2'b01,
    ST_FLUSH      = 2'b10
  } cc_state_t;

endpackage

// File: rtl/commit_controller.sv
// In-order commit stage. Retires the ROB head one entry per cycle:
//   - register writes / branches pop immediately and drive the RF commit port
//   - a mispredicted branch also raises rollback + redirect, then spends one
//     cycle in FLUSH with every output quiet
//   - a store is handed to the LSB (store_commit_*) and the head is popped
//     only once the LSB reports store_done
// Ports:
//   clk, rst_n (async, active-low), rdy (global enable, 0 freezes)
//   head_*            : ROB head entry
//   pop_head          : ROB dequeues its head this cycle
//   commit_*          : register-file commit port
//   rollback_flag     : global flush
//   redirect_valid/pc : fetch redirect
//   store_commit_*    : store release to LSB; store_done: LSB completion pulse
//   retired_count     : number of popped entries (wraps)
module commit_controller
  import commit_controller_pkg::*;
#(
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                head_valid,
  input  logic                head_ready,
  input  logic [ROB_ID_W-1:0] head_rob_id,
  input  logic [4:0]          head_rd,
  input  logic [DATA_W-1:0]   head_value,
  input  logic [1:0]          head_type,
  input  logic                head_mispredict,
  input  logic [DATA_W-1:0]   head_target_pc,
  output logic                pop_head,
  output logic                commit_flag,
  output logic [4:0]          commit_rd,
  output logic [ROB_ID_W-1:0] commit_rob_id,
  output logic [DATA_W-1:0]   commit_value,
  output logic                rollback_flag,
  output logic                redirect_valid,
  output logic [DATA_W-1:0]   redirect_pc,
  output logic                store_commit_valid,
  output logic [ROB_ID_W-1:0] store_commit_rob_id,
  input  logic                store_done,
  output logic [31:0]         retired_count
);

  cc_state_t  state, state_nxt;
  logic       done_flag, done_flag_nxt;
  head_type_t ht;

  assign ht = head_type_t'(head_type);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      done_flag     <= 1'b0;
      retired_count <= '0;
    end else begin
      state     <= state_nxt;
      done_flag <= done_flag_nxt;
      if (pop_head) begin
        retired_count <= retired_count + 32'd1;
      end
    end
  end

  always_comb begin
    state_nxt           = state;
    done_flag_nxt       = done_flag;
    pop_head            = 1'b0;
    commit_flag         = 1'b0;
    commit_rd           = '0;
    commit_rob_id       = '0;
    commit_value        = '0;
    rollback_flag       = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    store_commit_valid  = 1'b0;
    store_commit_rob_id = '0;

    if (rdy) begin
      unique case (state)
        ST_IDLE: begin
          if (head_valid && head_ready) begin
            if (ht == HT_STORE) begin
              store_commit_valid  = 1'b1;
              store_commit_rob_id = head_rob_id;
              state_nxt           = ST_STORE_WAIT;
            end else begin
              pop_head = 1'b1;
              if (head_rd != ZERO_REG) begin
                commit_flag   = 1'b1;
                commit_rd     = head_rd;
                commit_rob_id = head_rob_id;
                commit_value  = head_value;
              end
              if (ht == HT_BRANCH && head_mispredict) begin
                rollback_flag  = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = head_target_pc;
                state_nxt      = ST_FLUSH;
              end
            end
          end
        end
        ST_STORE_WAIT: begin
          if (store_done || done_flag) begin
            pop_head      = 1'b1;
            done_flag_nxt = 1'b0;
            state_nxt     = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end else if (state == ST_STORE_WAIT && store_done) begin
      // A completion seen while frozen must not be lost; remember it.
      done_flag_nxt = 1'b1;
    end
  end

endmodule
